// File: rtl/div_pkg.sv
// Shared constants and FSM state encoding for the arbitrated divider.
package div_pkg;

    localparam int unsigned DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_core.sv
// Restoring shift-subtract unsigned divider; one quotient bit per enabled cycle.
module div_core
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             en,
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    output logic [DIV_W-1:0] q,
    output logic [DIV_W-1:0] r
);

    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W:0]   trial;
    logic [DIV_W-1:0] diff;

    // quo_q shifts dividend bits out of its MSB while quotient bits enter at the LSB.
    // A zero divisor always subtracts, giving q = all ones and r = dividend.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        div_d = div_q;
        trial = {rem_q, quo_q[DIV_W-1]};
        diff  = trial[DIV_W-1:0] - div_q;
        if (ld) begin
            rem_d = '0;
            quo_d = a;
            div_d = b;
        end else if (en) begin
            if (trial >= {1'b0, div_q}) begin
                rem_d = diff;
                quo_d = {quo_q[DIV_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DIV_W-1:0];
                quo_d = {quo_q[DIV_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            div_q <= div_d;
        end
    end

    assign q = quo_q;
    assign r = rem_q;

endmodule

// File: rtl/div_arb.sv
// Round-robin arbiter sharing one div_core between two request/ack clients.
module div_arb
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [DIV_W-1:0] a0,
    input  logic [DIV_W-1:0] b0,
    input  logic             req1,
    input  logic [DIV_W-1:0] a1,
    input  logic [DIV_W-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [DIV_W-1:0] q,
    output logic [DIV_W-1:0] r,
    output logic             dz,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(DIV_W);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             gnt_q, gnt_d;
    logic             dz_q, dz_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;

    logic             gnt_c;
    logic             ld, en;
    logic [DIV_W-1:0] a_sel, b_sel;
    logic [DIV_W-1:0] core_q, core_r;

    // last_q records who was served last; contention goes to the other one.
    always_comb begin
        gnt_c = (req0 && req1) ? ~last_q : req1;
        a_sel = gnt_c ? a1 : a0;
        b_sel = gnt_c ? b1 : b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        dz_d    = dz_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        ld      = 1'b0;
        en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    ld      = 1'b1;
                    gnt_d   = gnt_c;
                    last_d  = gnt_c;
                    dz_d    = (b_sel == '0);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                en    = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_W - 1)) begin
                    state_d = DONE;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            dz_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            dz_q    <= dz_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    div_core u_core (
        .clk (clk),
        .rst (rst),
        .ld  (ld),
        .en  (en),
        .a   (a_sel),
        .b   (b_sel),
        .q   (core_q),
        .r   (core_r)
    );

    // Result lines read as zero outside the single ack cycle.
    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign busy = (state_q != IDLE);
    assign q    = (ack0_q || ack1_q) ? core_q : '0;
    assign r    = (ack0_q || ack1_q) ? core_r : '0;
    assign dz   = (ack0_q || ack1_q) && dz_q;

endmodule

// File: doc/div_arb.md
DIV_ARB -- requirements
Module: div_arb

Interface
REQ-001 SHALL have no parameters; operand width fixed at 4 bits (package constant DIV_W = 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0  input  1  requester 0 request; held until ack0.
REQ-005 a0, b0  input  4 each  requester 0 dividend, divisor; stable while req0 high.
REQ-006 req1  input  1  requester 1 request; held until ack1.
REQ-007 a1, b1  input  4 each  requester 1 dividend, divisor; stable while req1 high.
REQ-008 ack0, ack1  output  1 each  one-cycle result strobe to the granted requester.
REQ-009 q  output  4  quotient; valid only while ack0 or ack1 is high.
REQ-010 r  output  4  remainder; valid only while ack0 or ack1 is high.
REQ-011 dz  output  1  divide-by-zero flag; valid only with ack.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL share one shift-subtract 4-bit unsigned divider between two requesters.
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 IDLE, any req high at an edge: SHALL grant one requester, latch its a/b into the core, clear the iteration count to 0, and go BUSY.
REQ-016 BUSY: SHALL perform one restoring iteration per edge, 4 iterations total, then go DONE on the 4th iteration edge.
REQ-017 DONE: SHALL assert ack of the granted requester for exactly one cycle, present q/r/dz, then go IDLE.
REQ-018 Latency: ack high in the cycle after the 4th edge following the grant edge; throughput 1 op per 6 cycles.
REQ-019 Arbitration: round-robin; on simultaneous req0 and req1, grant the requester not served last; a lone requester is always granted, even if served last.
REQ-020 Priority pointer SHALL update only at the grant edge.
REQ-021 Requests arriving in BUSY/DONE SHALL be ignored until IDLE; no queuing.
REQ-022 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-023 Divisor 0: q = 4'b1111, r = dividend, dz = 1; latency identical to REQ-018.
REQ-024 q, r, dz SHALL be 0 whenever no ack is high.
REQ-025 ack0 and ack1 SHALL never be high together.

Reset
REQ-026 rst high SHALL immediately force IDLE, ack0 = ack1 = 0, busy = 0, q = r = 0, dz = 0, core registers 0, and round-robin pointer = requester 0 first.
REQ-027 Reset mid-operation SHALL abort it with no ack; the requester's req remains pending and is served after release.

Structure
REQ-028 Package div_pkg SHALL hold DIV_W and the FSM state enum (IDLE, BUSY, DONE).
REQ-029 Sub-module div_core SHALL hold the remainder/quotient shift registers and perform one iteration per enable, with inputs clk, rst, ld, en, a, b and outputs q, r.
REQ-030 div_arb SHALL hold the FSM, the iteration counter, the round-robin pointer and the output gating.

Verification
REQ-031 req0, a0=1011, b0=0010 -> ack0 4 cycles after grant, q=0101, r=0001, dz=0.
REQ-032 req1, a1=1001, b1=1000 -> ack1, q=0001, r=0001.
REQ-033 req0 and req1 high from reset release (a0=1111/b0=0011, a1=0110/b1=0100) -> ack0 first (q=0101, r=0000), then ack1 (q=0001, r=0010); ack1 follows ack0 by 6 cycles.
REQ-034 a0=0111, b0=0000 -> ack0, q=1111, r=0111, dz=1.
REQ-035 rst pulsed 2 cycles after grant of req0 -> no ack, busy=0 at once; after release req0 is re-granted and acked with the correct result.
REQ-036 req0 held high continuously, req1 low -> ack0 every 6 cycles; a req1 raised during BUSY is granted at the next IDLE ahead of req0.
